fifo_rd_drain: RTL and testbench
================================

Name: fifo_rd_drain

Overview:
Read-side consumer for the asynchronous FIFO. It runs entirely in the read clock domain. It issues read enables against the FIFO's registered empty flag and one-cycle-latency registered read data. It re-presents the words as a valid/ready stream through a 3-entry skid buffer, sustaining 1 word/cycle with no combinational path from m_ready to fifo_r_en. It also counts delivered words for status.

Parameters:
DATA_WIDTH, 8, width of FIFO read data and stream data
CNT_WIDTH, 16, width of delivered-word counter

Ports:
rclk  input  1  read-domain clock; all logic on rising edge
rrst_n  input  1  asynchronous active-low reset
enable  input  1  1 = drain FIFO; 0 = stop issuing new reads
fifo_empty  input  1  FIFO empty flag, registered in rclk domain
fifo_rdata  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_r_en
fifo_r_en  output  1  FIFO read enable (combinational from registered state + fifo_empty + enable)
m_valid  output  1  stream data valid
m_data  output  DATA_WIDTH  stream data (buffer head)
m_ready  input  1  downstream ready
rd_count  output  CNT_WIDTH  words accepted downstream (m_valid & m_ready), wraps
busy  output  1  occupancy != 0 or a read is in flight

Behaviour:
- Reset (rrst_n=0, async): occupancy=0, inflight=0, buffer pointers=0, rd_count=0. Outputs: m_valid=0, m_data=0, fifo_r_en=0, busy=0. A read in flight at reset is discarded.
- State:
  - 3-entry circular buffer: wr_idx, rd_idx in 0..2, each wraps 2->0.
  - occupancy in 0..3.
  - inflight flag = fifo_r_en registered.
- Read issue: fifo_r_en = enable & ~fifo_empty & (occupancy + inflight < 3). It never depends on m_ready.
- Capture: in the cycle where inflight=1, fifo_rdata is written at wr_idx and wr_idx advances.
- Stream side:
  - m_valid = (occupancy != 0).
  - m_data = entry[rd_idx], registered storage, no bypass.
  - Pop = m_valid & m_ready; on pop, rd_idx advances.
- Same-cycle capture and pop: occupancy is unchanged and both indices advance.
- Overflow is impossible by construction. Occupancy never exceeds 3; the bench must assert this.
- Hold rule: while m_valid=1 and m_ready=0, m_data must not change and m_valid must not drop.
- Latency: first word reaches m_valid 2 cycles after fifo_r_en (1 cycle FIFO read + 1 cycle capture). Steady state with m_ready=1 is 1 word/cycle.
- enable deassert mid-stream:
  - No new fifo_r_en from the same cycle.
  - An in-flight read is still captured.
  - Buffered words are still delivered.
  - busy falls once drained.
- fifo_empty asserting with a read in flight: that read is still captured. fifo_r_en drops the same cycle.
- rd_count increments by 1 per pop and wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
1. Reset, then FIFO holds 0x11,0x22,0x33, enable=1, m_ready=1 -> fifo_r_en high 3 consecutive cycles; m_valid high 3 cycles starting 2 cycles after first fifo_r_en; m_data 0x11,0x22,0x33; rd_count=3; busy=0 afterward.
2. FIFO holds 8 words, m_ready=0 -> exactly 3 fifo_r_en pulses; occupancy saturates at 3; m_data stays 0x(first word). Then m_ready=1 -> all 8 words in order, no gap after refill; rd_count=8.
3. m_ready toggles 1,0,1,0 with continuous FIFO data -> no word dropped or duplicated; m_data stable during every m_ready=0 cycle.
4. enable drops the cycle after a fifo_r_en -> no further fifo_r_en; the in-flight word is still delivered; busy clears once drained.
5. rrst_n pulsed low mid-stream with occupancy=2 -> m_valid=0, rd_count=0, fifo_r_en=0 immediately (async); after release, normal draining resumes.
6. CNT_WIDTH=4, deliver 17 words -> rd_count reads 1.

Source files
------------

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-domain FIFO drain into a 3-entry skid-buffered stream
//
// Purpose: issues read enables against a registered-empty, one-cycle-latency FIFO
// and re-presents the words as a valid/ready stream at up to one word per cycle.
// Reads are throttled by local credit only, so m_ready never reaches fifo_r_en.
//
// Ports:
//   rclk        read-domain clock, rising edge
//   rrst_n      asynchronous active-low reset
//   enable      1 = keep draining; 0 = issue no new reads
//   fifo_empty  registered FIFO empty flag
//   fifo_rdata  FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en   FIFO read enable
//   m_valid     stream valid (buffer non-empty)
//   m_data      stream data (buffer head, registered)
//   m_ready     downstream ready
//   rd_count    words accepted downstream, wrapping
//   busy        words buffered or a read in flight
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);

    localparam logic [1:0] LAST_IDX = 2'd2;
    localparam logic [2:0] DEPTH    = 3'd3;

    logic [DATA_WIDTH-1:0] entry [3];
    logic [1:0]            wr_idx;
    logic [1:0]            rd_idx;
    logic [1:0]            occupancy;
    logic                  inflight;
    logic [2:0]            committed;
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    endfunction

    // A read already in flight has claimed a slot, so credit counts it too.
    // Using the pre-pop occupancy is what keeps m_ready out of this path;
    // three entries are enough to cover the two-cycle read loop without gaps.
    assign committed = {1'b0, occupancy} + {2'b00, inflight};
    assign fifo_r_en = rrst_n & enable & ~fifo_empty & (committed < DEPTH);

    assign capture = inflight;
    assign m_valid = (occupancy != 2'd0);
    assign pop     = m_valid & m_ready;
    assign busy    = m_valid | inflight;

    always_comb begin
        m_data = entry[2];
        case (rd_idx)
            2'd0:    m_data = entry[0];
            2'd1:    m_data = entry[1];
            default: m_data = entry[2];
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < 3; i++) begin
                entry[i] <= '0;
            end
            wr_idx    <= 2'd0;
            rd_idx    <= 2'd0;
            occupancy <= 2'd0;
            inflight  <= 1'b0;
            rd_count  <= '0;
        end else begin
            inflight <= fifo_r_en;

            if (capture) begin
                for (int i = 0; i < 3; i++) begin
                    if (wr_idx == 2'(i)) begin
                        entry[i] <= fifo_rdata;
                    end
                end
                wr_idx <= next_idx(wr_idx);
            end

            if (pop) begin
                rd_idx   <= next_idx(rd_idx);
                rd_count <= rd_count + CNT_WIDTH'(1);
            end

            case ({capture, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - self-checking bench for fifo_rd_drain
module tb_fifo_rd_drain;

    localparam int DW = 8;

    logic          rclk       = 1'b0;
    logic          rrst_n     = 1'b0;
    logic          enable     = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          m_ready    = 1'b0;

    logic          fifo_r_en, m_valid, busy;
    logic [DW-1:0] m_data;
    logic [15:0]   rd_count;
    logic          fifo_r_en4, m_valid4, busy4;
    logic [DW-1:0] m_data4;
    logic [3:0]    rd_count4;

    fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count), .busy(busy)
    );

    fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_r_en(fifo_r_en4), .m_valid(m_valid4),
        .m_data(m_data4), .m_ready(m_ready), .rd_count(rd_count4), .busy(busy4)
    );

    always #5 rclk = ~rclk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // FIFO emulation: registered empty flag, read data one cycle after r_en.
    logic [DW-1:0] fq[$];
    always @(posedge rclk) begin
        if (fifo_r_en) begin
            if (fq.size() == 0) chk("fifo_underrun", 1, 0);
            else fifo_rdata <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Reference model: words in the buffer as a queue, plus one in-flight flag.
    logic [DW-1:0] mq[$];
    bit            m_infl;
    int unsigned   m_cnt;
    bit            do_pop, do_rd;

    function automatic bit exp_ren();
        return rrst_n && enable && !fifo_empty && ((mq.size() + int'(m_infl)) < 3);
    endfunction

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            mq.delete();
            m_infl = 1'b0;
            m_cnt  = 0;
        end else begin
            do_pop = (mq.size() != 0) && m_ready;
            do_rd  = exp_ren();
            if (do_pop) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (m_infl) mq.push_back(fifo_rdata);
            m_infl = do_rd;
            chk("occupancy_le_3", (mq.size() <= 3), 1);
        end
    end

    // Per-cycle compare plus event recording for the directed checks.
    int            cyc = 0;
    int            ren_cnt, valid_cnt, first_ren, last_ren, first_valid, first_pop, last_pop, hold_seen;
    logic [DW-1:0] delv[$];
    bit            prev_hold;
    logic [DW-1:0] prev_data;

    always @(posedge rclk) cyc++;

    always @(negedge rclk) begin
        if (!rrst_n) begin
            chk("rst_fifo_r_en", fifo_r_en, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rd_count", rd_count, 0);
            prev_hold = 1'b0;
        end else begin
            chk("fifo_r_en", fifo_r_en, exp_ren());
            chk("m_valid", m_valid, mq.size() != 0);
            if (mq.size() != 0) chk("m_data", m_data, mq[0]);
            chk("busy", busy, (mq.size() != 0) || m_infl);
            chk("rd_count", rd_count, m_cnt[15:0]);
            chk("fifo_r_en4", fifo_r_en4, exp_ren());
            chk("m_valid4", m_valid4, mq.size() != 0);
            if (mq.size() != 0) chk("m_data4", m_data4, mq[0]);
            chk("busy4", busy4, (mq.size() != 0) || m_infl);
            chk("rd_count4", rd_count4, m_cnt[3:0]);
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                hold_seen++;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (fifo_r_en) begin
                if (first_ren < 0) first_ren = cyc;
                last_ren = cyc;
                ren_cnt++;
            end
            if (m_valid) begin
                if (first_valid < 0) first_valid = cyc;
                valid_cnt++;
            end
            if (m_valid && m_ready) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                delv.push_back(m_data);
            end
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic clear_stats();
        ren_cnt = 0; valid_cnt = 0; hold_seen = 0;
        first_ren = -1; last_ren = -1; first_valid = -1; first_pop = -1; last_pop = -1;
        delv.delete();
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
    endtask

    task automatic do_reset();
        rrst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        tick(); tick();
        rrst_n = 1'b1;
        clear_stats();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (3) tick();
        while (!(fq.size() == 0 && fifo_empty && !busy && !m_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < budget, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: three words, free-running downstream
        do_reset();
        push(8'h11); push(8'h22); push(8'h33);
        tick(); tick();
        clear_stats();
        enable = 1'b1; m_ready = 1'b1;
        wait_idle(50);
        chk("t1_ren_pulses", ren_cnt, 3);
        chk("t1_ren_span", last_ren - first_ren, 2);
        chk("t1_latency", first_valid - first_ren, 2);
        chk("t1_valid_cycles", valid_cnt, 3);
        chk("t1_words", delv.size(), 3);
        chk("t1_w0", delv[0], 8'h11);
        chk("t1_w1", delv[1], 8'h22);
        chk("t1_w2", delv[2], 8'h33);
        chk("t1_rd_count", rd_count, 3);
        chk("t1_busy", busy, 0);

        // 2: stalled downstream saturates at three, then drains with no gap
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        enable = 1'b1;
        repeat (12) tick();
        chk("t2_ren_stalled", ren_cnt, 3);
        chk("t2_valid_stalled", m_valid, 1);
        chk("t2_data_stalled", m_data, 8'h40);
        m_ready = 1'b1;
        wait_idle(60);
        chk("t2_words", delv.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_order", delv[i], 8'(8'h40 + i));
        chk("t2_no_gap", last_pop - first_pop, 7);
        chk("t2_rd_count", rd_count, 8);

        // 3: toggling ready
        do_reset();
        for (int i = 0; i < 10; i++) push(8'(8'h60 + i));
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        m_ready = 1'b1;
        wait_idle(60);
        chk("t3_words", delv.size(), 10);
        for (int i = 0; i < 10; i++) chk("t3_order", delv[i], 8'(8'h60 + i));
        chk("t3_rd_count", rd_count, 10);
        chk("t3_hold_seen", hold_seen > 0, 1);

        // 4: enable drops right after one read
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
        tick(); tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (10) tick();
        chk("t4_ren_pulses", ren_cnt, 1);
        chk("t4_words", delv.size(), 1);
        chk("t4_w0", delv[0], 8'h70);
        chk("t4_busy", busy, 0);
        chk("t4_rd_count", rd_count, 1);
        chk("t4_fifo_left", fq.size(), 4);

        // 5: async reset with two words buffered
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        push(8'h80);
        repeat (6) tick();
        m_ready = 1'b0;
        push(8'h81); push(8'h82);
        repeat (8) tick();
        chk("t5_pre_rd_count", rd_count, 1);
        chk("t5_pre_data", m_data, 8'h81);
        chk("t5_pre_ren", ren_cnt, 3);
        @(posedge rclk);
        #3 rrst_n = 1'b0;
        #1;
        chk("t5_async_valid", m_valid, 0);
        chk("t5_async_rd_count", rd_count, 0);
        chk("t5_async_ren", fifo_r_en, 0);
        chk("t5_async_busy", busy, 0);
        @(posedge rclk);
        #1 rrst_n = 1'b1;
        clear_stats();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'h90 + i));
        wait_idle(60);
        chk("t5_words", delv.size(), 4);
        for (int i = 0; i < 4; i++) chk("t5_order", delv[i], 8'(8'h90 + i));
        chk("t5_rd_count", rd_count, 4);

        // 6: narrow counter wraps
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(8'hA0 + i));
        wait_idle(100);
        chk("t6_words", delv.size(), 17);
        chk("t6_rd_count4", rd_count4, 1);
        chk("t6_rd_count16", rd_count, 17);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
